// File: rtl/sat_capture_stage.sv
// sat_capture_stage: capture end of a launch path. Accepts words over valid/ready,
// applies a saturating add of OFFSET ("logic c"), and presents the results through a
// registered output stage with a one-entry skid buffer. in_ready and out_valid are
// both flops, so no combinational path crosses the block boundary.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in_valid    upstream word present
//   in_ready    block can accept a word this cycle (registered)
//   in_data     upstream word
//   out_valid   out_data/out_sat hold a valid result (registered)
//   out_ready   downstream accepts this cycle
//   out_data    transformed word
//   out_sat     out_data was saturated; travels with the word
//   xfer_count  completed output transfers, modulo 2^16
module sat_capture_stage #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned OFFSET = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat,
    output logic [15:0]      xfer_count
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] skid_data;
    logic             skid_sat;

    logic [WIDTH-1:0] off_c;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] res_data_c;
    logic             res_sat_c;
    logic             in_fire_c;
    logic             out_fire_c;

    // Logic c: saturating add, applied before the word is stored.
    assign off_c      = WIDTH'(OFFSET);
    assign sum_c      = {1'b0, in_data} + {1'b0, off_c};
    assign res_sat_c  = sum_c[WIDTH];
    assign res_data_c = sum_c[WIDTH] ? {WIDTH{1'b1}} : sum_c[WIDTH-1:0];

    assign in_fire_c  = in_valid & in_ready;
    assign out_fire_c = out_valid & out_ready;

    // Buffer control; in_ready comes out of reset low and rises on the first edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sat    <= 1'b0;
            skid_data  <= '0;
            skid_sat   <= 1'b0;
            xfer_count <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    in_ready <= 1'b1;
                    if (in_fire_c) begin
                        out_data  <= res_data_c;
                        out_sat   <= res_sat_c;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire_c && out_fire_c) begin
                        // New word replaces the departing one, no bubble.
                        out_data <= res_data_c;
                        out_sat  <= res_sat_c;
                    end else if (in_fire_c) begin
                        skid_data <= res_data_c;
                        skid_sat  <= res_sat_c;
                        in_ready  <= 1'b0;
                        state     <= FULL;
                    end else if (out_fire_c) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire_c) begin
                        out_data <= skid_data;
                        out_sat  <= skid_sat;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase

            if (out_fire_c) begin
                xfer_count <= xfer_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/sat_capture_stage.md
# sat_capture_stage

Receiving (capture) end of a register-to-register launch path: accepts words from an upstream launching stage over a valid/ready handshake and applies the capture-side "logic c" transform, a saturating add of a constant. It stores results in a registered output with a one-entry skid buffer, so both `in_ready` and `out_valid` come straight from flops and no combinational path crosses the block boundary. It sits directly after the launch/combinational stages in a pipeline and feeds a downstream consumer.

## Interface
- `WIDTH`, 8: data width in bits (≥2).
- `OFFSET`, 1: unsigned constant added in logic c, WIDTH bits.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream word present.
- `in_ready`  out  1  registered; block can accept a word this cycle.
- `in_data`  in  WIDTH  upstream word.
- `out_valid`  out  1  registered; `out_data` holds a valid result.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  WIDTH  transformed word.
- `out_sat`  out  1  set when `out_data` was saturated; travels with the word.
- `xfer_count`  out  16  number of completed output transfers, modulo 2^16.

## Operation
- `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- Logic c: `sum = {1'b0,in_data} + OFFSET` at WIDTH+1 bits. If `sum[WIDTH]` is set, the result is all ones and the sat bit is 1. Otherwise the result is `sum[WIDTH-1:0]` and the sat bit is 0.
- Logic c is applied at input, before storage. The output register and the skid register both hold transformed data and the sat bit.
- FSM states: EMPTY (out_valid=0, in_ready=1), ONE (out_valid=1, in_ready=1), FULL (out_valid=1, in_ready=0).
- EMPTY:
  - On `in_fire`, load the output register and go to ONE.
  - Otherwise stay.
- ONE:
  - `in_fire & out_fire`: load the output register with the new word and stay in ONE.
  - `in_fire & !out_fire`: load the skid register and go to FULL.
  - `!in_fire & out_fire`: go to EMPTY.
  - Otherwise hold.
- FULL:
  - On `out_fire`, move skid into the output register and go to ONE.
  - Otherwise hold.
  - `in_valid` is ignored because `in_ready` is 0.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- `out_data` and `out_sat` stay stable while `out_valid=1 & out_ready=0`.
- `xfer_count` increments by 1 on each `out_fire` and wraps from 0xFFFF to 0x0000.

## Timing
- Reset, asynchronous and taking effect immediately:
  - state=EMPTY, `in_ready`=0, `out_valid`=0, `out_data`=0, `out_sat`=0, `xfer_count`=0, skid=0.
- First rising edge after `rst` falls: `in_ready`=1. No transfer can occur on that edge.
- Latency: a word accepted at edge k appears on `out_data` with `out_valid`=1 after edge k (visible in cycle k+1).
- Throughput: 1 word/cycle sustained while `out_ready`=1.
- `in_ready` drops the cycle after the skid is filled. It returns to 1 the cycle after the `out_fire` that empties the skid.
- Simultaneous `in_fire` and `out_fire` in ONE: the new word replaces the departing one, with no bubble.
- Reset asserted mid-operation: all buffered words are discarded, all outputs return to their reset values immediately, and the count is cleared.
- Saturation boundary: `in_data = 2^WIDTH-1-OFFSET` gives exactly all ones with `out_sat`=0. One greater gives all ones with `out_sat`=1.

## Test plan
- Reset/startup:
  - Stimulus: assert `rst` mid-cycle with data buffered in FULL.
  - Required: all outputs go to 0 immediately.
  - Required: `in_ready` goes to 1 exactly one edge after release.
- Streaming, WIDTH=8, OFFSET=1:
  - Stimulus: send 0x00,0x10,0xFE,0xFF with `out_ready`=1.
  - Required: outputs 0x01,0x11,0xFF(sat 0),0xFF(sat 1), each one cycle after acceptance.
  - Required: `xfer_count`=4.
- Backpressure:
  - Stimulus: hold `out_ready`=0 and offer 3 words A,B,C.
  - Required: A held on output, B in skid, `in_ready`=0, C not accepted.
  - Then: release `out_ready` and check the sequence A,B,C with no loss and no duplication.
- Simultaneous fire:
  - Stimulus: in ONE, drive `in_fire` and `out_fire` together every cycle for 10 cycles.
  - Required: state stays ONE, `in_ready` stays 1, and outputs are in order.
- Count wrap:
  - Stimulus: preload with 65535 transfers, then one more.
  - Required: `xfer_count` reads 0xFFFF, then 0x0000.
- Random:
  - Stimulus: randomized `in_valid`/`out_ready` for 10k cycles against a scoreboard model.
  - Required: exact order and values.
  - Required: `out_data` stable under stall.
  - Required: `in_ready`=0 only in FULL.
